// File: rtl/effect_pkg.sv
// Shared definitions for the effect parameter controller: FSM states,
// one-hot status bit positions and the effect slot numbering.
package effect_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_PLAY,
    ST_SET,
    ST_RECD,
    ST_LOOP
  } state_e;

  localparam int OH_INIT = 0;
  localparam int OH_PLAY = 1;
  localparam int OH_SET  = 2;
  localparam int OH_RECD = 3;
  localparam int OH_LOOP = 4;

  localparam int GATE = 0;
  localparam int COMP = 1;
  localparam int DIST = 2;
  localparam int EQ_B = 3;
  localparam int EQ_T = 4;
  localparam int TREM = 5;
  localparam int CHOR = 6;
  localparam int DEL  = 7;

  function automatic logic [4:0] state_onehot(input state_e s);
    logic [4:0] oh;
    oh = '0;
    case (s)
      ST_INIT: oh[OH_INIT] = 1'b1;
      ST_PLAY: oh[OH_PLAY] = 1'b1;
      ST_SET:  oh[OH_SET]  = 1'b1;
      ST_RECD: oh[OH_RECD] = 1'b1;
      ST_LOOP: oh[OH_LOOP] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for one debounced key; the previous level resets
// high so a key held through reset produces no event.
module key_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_evt
);

  logic prev_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) prev_q <= 1'b1;
    else       prev_q <= i_key;
  end

  assign o_evt = i_key & ~prev_q;

endmodule

// File: rtl/effect_param_ctrl.sv
// Front-panel controller: edits effect parameters in SET mode and drives
// loop-memory record/playback strobes in step with the sample tick.
module effect_param_ctrl
  import effect_pkg::*;
#(
  parameter  int NUM_FX = 8,
  parameter  int PW     = 3,
  parameter  int AW     = 20,
  parameter  int WRAP   = 1,
  localparam int SW     = $clog2(NUM_FX)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_init_done,
  input  logic                 i_key_inc,
  input  logic                 i_key_dec,
  input  logic                 i_key_loop,
  input  logic                 i_key_mode,
  input  logic [SW-1:0]        i_sel,
  input  logic                 i_sample_tick,
  output logic [NUM_FX*PW-1:0] o_params,
  output logic [PW-1:0]        o_cur_val,
  output logic [4:0]           o_state,
  output logic                 o_rec_we,
  output logic                 o_play_re,
  output logic [AW-1:0]        o_addr,
  output logic [AW-1:0]        o_loop_len
);

  localparam logic [AW-1:0] MAX_LEN = {AW{1'b1}};
  localparam logic [PW-1:0] MAX_P   = {PW{1'b1}};

  logic inc_evt, dec_evt, loop_evt, mode_evt;

  key_edge u_inc  (.i_clk(i_clk), .i_rst(i_rst), .i_key(i_key_inc),  .o_evt(inc_evt));
  key_edge u_dec  (.i_clk(i_clk), .i_rst(i_rst), .i_key(i_key_dec),  .o_evt(dec_evt));
  key_edge u_loop (.i_clk(i_clk), .i_rst(i_rst), .i_key(i_key_loop), .o_evt(loop_evt));
  key_edge u_mode (.i_clk(i_clk), .i_rst(i_rst), .i_key(i_key_mode), .o_evt(mode_evt));

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic [PW-1:0] param_q [NUM_FX];
  logic [PW-1:0] param_d [NUM_FX];
  logic          sel_ok;

  assign sel_ok = (int'(i_sel) < NUM_FX);

  function automatic logic [PW-1:0] step_param(input logic [PW-1:0] v, input logic up);
    if (up) return (v == MAX_P) ? ((WRAP != 0) ? '0 : MAX_P) : v + 1'b1;
    else    return (v == '0)    ? ((WRAP != 0) ? MAX_P : '0) : v - 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      param_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      param_q <= param_d;
    end
  end

  // A tick is always handled by the current state, even when a key event
  // moves the FSM away on the same edge; entry clears then override cnt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    param_d = param_q;
    case (state_q)
      ST_INIT: begin
        if (i_init_done) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (mode_evt) begin
          state_d = ST_SET;
        end else if (loop_evt) begin
          state_d = ST_RECD;
          cnt_d   = '0;
          len_d   = '0;
        end
      end
      ST_SET: begin
        if (mode_evt) state_d = ST_PLAY;
        if (sel_ok && (inc_evt ^ dec_evt))
          param_d[i_sel] = step_param(param_q[i_sel], inc_evt);
      end
      ST_RECD: begin
        if (i_sample_tick) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          cnt_d  = cnt_q + 1'b1;
          len_d  = cnt_q + 1'b1;
        end
        if (i_sample_tick && (cnt_q == MAX_LEN - 1'b1)) begin
          state_d = ST_LOOP;
          cnt_d   = '0;
        end else if (loop_evt) begin
          state_d = (len_q != '0) ? ST_LOOP : ST_PLAY;
          cnt_d   = '0;
        end
      end
      ST_LOOP: begin
        if (i_sample_tick) begin
          re_d   = 1'b1;
          addr_d = cnt_q;
          cnt_d  = (cnt_q == len_q - 1'b1) ? '0 : cnt_q + 1'b1;
        end
        if (loop_evt) state_d = ST_PLAY;
      end
      default: state_d = ST_INIT;
    endcase
  end

  for (genvar k = 0; k < NUM_FX; k++) begin : g_params
    assign o_params[k*PW +: PW] = param_q[k];
  end

  assign o_cur_val  = (state_q == ST_SET && sel_ok) ? param_q[i_sel] : '0;
  assign o_state    = state_onehot(state_q);
  assign o_rec_we   = we_q;
  assign o_play_re  = re_q;
  assign o_addr     = addr_q;
  assign o_loop_len = len_q;

endmodule

// File: doc/effect_param_ctrl.md
EFFECT_PARAM_CTRL -- requirements
Module: effect_param_ctrl

Interface
REQ-001 Parameter NUM_FX, default 8: number of effect parameter slots.
REQ-002 Parameter PW, default 3: width of each effect parameter.
REQ-003 Parameter AW, default 20: loop address width; maximum loop length is 2^AW-1 samples.
REQ-004 Parameter WRAP, default 1: 1 = parameters wrap at limits; 0 = parameters saturate.
REQ-005 Derived SW = $clog2(NUM_FX): select width.
REQ-006 i_clk  in  1  single clock; the audio bit clock domain.
REQ-007 i_rst  in  1  reset: one clock; reset is synchronous and active-high.
REQ-008 i_init_done  in  1  codec I2C initialisation finished (level).
REQ-009 i_key_inc, i_key_dec, i_key_loop, i_key_mode  in  1 each  debounced key levels, active-high.
REQ-010 i_sel  in  SW  selected effect slot.
REQ-011 i_sample_tick  in  1  one-cycle pulse per stereo sample.
REQ-012 o_params  out  NUM_FX*PW  slot k at bits [k*PW +: PW].
REQ-013 o_cur_val  out  PW  parameter of slot i_sel while in SET, else 0.
REQ-014 o_state  out  5  one-hot {LOOP,RECD,SET,PLAY,INIT}.
REQ-015 o_rec_we / o_play_re  out  1 each  one-cycle loop-memory write/read strobes.
REQ-016 o_addr  out  AW  loop-memory address, valid while a strobe is high.
REQ-017 o_loop_len  out  AW  length of the last recorded loop, in samples.

Function
REQ-018 Each key SHALL be rising-edge detected (level & ~previous level), so that a held key yields exactly one event.
REQ-019 The FSM SHALL transition INIT->PLAY when i_init_done=1.
REQ-020 From PLAY, a mode event SHALL go to SET; otherwise a loop event SHALL go to RECD; mode has priority over loop.
REQ-021 From SET, a mode event SHALL go to PLAY; loop events SHALL be ignored in SET.
REQ-022 From RECD, a loop event SHALL go to LOOP when o_loop_len>0 and to PLAY when o_loop_len=0; the FSM SHALL enter LOOP automatically when o_loop_len reaches 2^AW-1.
REQ-023 From LOOP, a loop event SHALL go to PLAY; mode events SHALL be ignored in RECD and LOOP.
REQ-024 Parameters SHALL change only in SET, and only on inc/dec events for slot i_sel; when i_sel>=NUM_FX, events are ignored and o_cur_val=0.
REQ-025 Simultaneous inc and dec events SHALL leave the parameter unchanged.
REQ-026 With WRAP=1, inc at 2^PW-1 SHALL give 0 and dec at 0 SHALL give 2^PW-1; with WRAP=0, the parameter SHALL clamp at both limits.
REQ-027 Entering RECD SHALL clear the address counter and o_loop_len to 0.
REQ-028 In RECD, each tick SHALL produce o_rec_we=1 exactly one cycle later, with o_addr=k (the k-th sample, 0-based); o_loop_len SHALL become k+1.
REQ-029 Entering LOOP SHALL clear the address counter to 0.
REQ-030 In LOOP, each tick SHALL produce o_play_re=1 one cycle later with o_addr; the address SHALL wrap to 0 after o_loop_len-1.
REQ-031 A tick arriving in the same cycle as a state-leaving event SHALL be processed by the old state.
REQ-032 o_loop_len SHALL hold its value in PLAY/SET until the next entry into RECD.

Reset
REQ-033 On i_rst=1 at a clock edge, the block SHALL set: state INIT (o_state=5'b00001), all parameters 0, o_cur_val=0, o_rec_we=o_play_re=0, o_addr=0, o_loop_len=0, and key-previous registers to 1 (a key held through reset gives no event).
REQ-034 Reset asserted mid-record or mid-loop SHALL abort immediately, with no further strobes.

Structure
REQ-035 Shared package effect_pkg SHALL hold the state enum, the one-hot o_state bit positions, and the effect-slot constants (GATE=0, COMP=1, DIST=2, EQ_B=3, EQ_T=4, TREM=5, CHOR=6, DEL=7).
REQ-036 Key edge detection SHALL be a sub-module key_edge, instantiated once per key.

Verification
REQ-037 Reset, then i_init_done=1 -> o_state=00001 during reset, 00010 one cycle after release.
REQ-038 SET, i_sel=5, i_key_inc held 10 cycles -> slot 5=1, all other slots 0.
REQ-039 PW=3: WRAP=1, 8 inc events -> 0; WRAP=0, dec at 0 -> 0, then 9 inc events -> 7; inc+dec in the same cycle -> unchanged.
REQ-040 PLAY, loop event, 5 ticks -> o_rec_we 5 pulses at addresses 0..4; loop event -> LOOP, o_loop_len=5; 7 ticks -> o_play_re at addresses 0,1,2,3,4,0,1.
REQ-041 AW=3: 7 ticks in RECD -> automatic LOOP, o_loop_len=7; a separate loop event with 0 ticks recorded -> PLAY, o_loop_len=0.
REQ-042 i_rst pulsed during LOOP -> next cycle o_state=00001, no strobes, o_loop_len=0.
